// File: rtl/pipe_pwr_ctrl_xn.sv
// PIPE power-state and receiver-detect controller for an N-lane ECP3 PCIe PHY.
// Produces PhyStatus, per-lane detect results, SERDES detect strobes and filtered RxElecIdle.
module pipe_pwr_ctrl_xn #(
   parameter int NUM_LANES     = 4,
   parameter int LOCK_WAIT     = 32,
   parameter int DET_CT_CYCLES = 16,
   parameter int DET_TIMEOUT   = 255,
   parameter int EI_FILT       = 8
) (
   input  logic                   PCLK,
   input  logic                   RESET,
   input  logic [1:0]             PowerDown,
   input  logic                   TxDetectRx_Loopback,
   input  logic [NUM_LANES-1:0]   TxElecIdle,
   input  logic                   ffs_plol,
   input  logic [NUM_LANES-1:0]   ffs_rlol,
   input  logic [NUM_LANES-1:0]   rx_ei_raw,
   input  logic [NUM_LANES-1:0]   ffs_pcie_done,
   input  logic [NUM_LANES-1:0]   ffs_pcie_con,
   output logic                   PhyStatus,
   output logic [3*NUM_LANES-1:0] RxStatus,
   output logic [NUM_LANES-1:0]   RxElecIdle,
   output logic                   ffc_pcie_det_en,
   output logic                   ffc_pcie_ct,
   output logic [1:0]             cur_pd
);

   localparam int LOCK_W = $clog2(LOCK_WAIT + 1);
   localparam int CT_W   = $clog2(DET_CT_CYCLES + 1);
   localparam int TO_W   = $clog2(DET_TIMEOUT + 1);
   localparam int DET_W  = (CT_W > TO_W) ? CT_W : TO_W;
   localparam int EI_W   = $clog2(EI_FILT + 1);

   typedef enum logic [2:0] {
      ST_LOCK,
      ST_IDLE,
      ST_DET_EN,
      ST_DET_CT,
      ST_DET_WAIT,
      ST_DET_RES,
      ST_DET_HOLD
   } state_t;

   state_t                 state_reg, state_next;
   logic [LOCK_W-1:0]      lock_cnt_reg, lock_cnt_next;
   logic [DET_W-1:0]       det_cnt_reg, det_cnt_next;
   logic                   phy_status_reg, phy_status_next;
   logic                   det_en_reg, det_en_next;
   logic                   ct_reg, ct_next;
   logic [1:0]             cur_pd_reg, cur_pd_next;
   logic [3*NUM_LANES-1:0] rx_status_reg, rx_status_next;
   logic [3*NUM_LANES-1:0] det_result;
   logic                   all_tx_idle;
   logic                   all_done;
   logic                   force_idle;

   assign all_tx_idle = &TxElecIdle;
   assign all_done    = &ffs_pcie_done;
   assign force_idle  = cur_pd_reg[1] || (state_reg == ST_LOCK);

   always_comb begin
      state_next      = state_reg;
      lock_cnt_next   = lock_cnt_reg;
      det_cnt_next    = det_cnt_reg;
      phy_status_next = 1'b0;
      det_en_next     = det_en_reg;
      ct_next         = ct_reg;
      cur_pd_next     = cur_pd_reg;
      rx_status_next  = '0;

      // Lock loss outranks everything outside ST_LOCK and aborts any detect.
      if ((state_reg != ST_LOCK) && ffs_plol) begin
         state_next      = ST_LOCK;
         phy_status_next = 1'b1;
         det_en_next     = 1'b0;
         ct_next         = 1'b0;
         lock_cnt_next   = '0;
         det_cnt_next    = '0;
      end else begin
         case (state_reg)
            ST_LOCK: begin
               phy_status_next = 1'b1;
               if (ffs_plol) begin
                  lock_cnt_next = '0;
               end else if (lock_cnt_reg == LOCK_W'(LOCK_WAIT - 1)) begin
                  lock_cnt_next   = '0;
                  phy_status_next = 1'b0;
                  cur_pd_next     = 2'b10;
                  state_next      = ST_IDLE;
               end else begin
                  lock_cnt_next = lock_cnt_reg + LOCK_W'(1);
               end
            end
            ST_IDLE: begin
               if (PowerDown != cur_pd_reg) begin
                  cur_pd_next     = PowerDown;
                  phy_status_next = 1'b1;
               end else if ((cur_pd_reg == 2'b10) && TxDetectRx_Loopback && all_tx_idle) begin
                  state_next   = ST_DET_EN;
                  det_en_next  = 1'b1;
                  det_cnt_next = '0;
               end
            end
            ST_DET_EN: begin
               if (det_cnt_reg == DET_W'(1)) begin
                  state_next   = ST_DET_CT;
                  ct_next      = 1'b1;
                  det_cnt_next = '0;
               end else begin
                  det_cnt_next = det_cnt_reg + DET_W'(1);
               end
            end
            ST_DET_CT: begin
               if (det_cnt_reg == DET_W'(DET_CT_CYCLES - 1)) begin
                  state_next   = ST_DET_WAIT;
                  ct_next      = 1'b0;
                  det_cnt_next = '0;
               end else begin
                  det_cnt_next = det_cnt_reg + DET_W'(1);
               end
            end
            ST_DET_WAIT: begin
               if (all_done) begin
                  state_next      = ST_DET_RES;
                  det_en_next     = 1'b0;
                  phy_status_next = 1'b1;
                  rx_status_next  = det_result;
                  det_cnt_next    = '0;
               end else if (det_cnt_reg == DET_W'(DET_TIMEOUT - 1)) begin
                  state_next      = ST_DET_RES;
                  det_en_next     = 1'b0;
                  phy_status_next = 1'b1;
                  det_cnt_next    = '0;
               end else begin
                  det_cnt_next = det_cnt_reg + DET_W'(1);
               end
            end
            ST_DET_RES: begin
               state_next = ST_DET_HOLD;
            end
            ST_DET_HOLD: begin
               if (!TxDetectRx_Loopback) begin
                  state_next = ST_IDLE;
               end
            end
            default: begin
               state_next      = ST_LOCK;
               phy_status_next = 1'b1;
               det_en_next     = 1'b0;
               ct_next         = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge PCLK) begin
      if (RESET) begin
         state_reg      <= ST_LOCK;
         lock_cnt_reg   <= '0;
         det_cnt_reg    <= '0;
         phy_status_reg <= 1'b1;
         det_en_reg     <= 1'b0;
         ct_reg         <= 1'b0;
         cur_pd_reg     <= 2'b10;
         rx_status_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         lock_cnt_reg   <= lock_cnt_next;
         det_cnt_reg    <= det_cnt_next;
         phy_status_reg <= phy_status_next;
         det_en_reg     <= det_en_next;
         ct_reg         <= ct_next;
         cur_pd_reg     <= cur_pd_next;
         rx_status_reg  <= rx_status_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         logic [EI_W-1:0] ei_cnt_reg, ei_cnt_next;
         logic            ei_reg;

         assign det_result[3*gi +: 3] = ffs_pcie_con[gi] ? 3'b011 : 3'b000;

         // Idle clears only once the saturating quiet-run count reaches EI_FILT.
         always_comb begin
            ei_cnt_next = ei_cnt_reg;
            if (force_idle || ffs_rlol[gi] || rx_ei_raw[gi]) begin
               ei_cnt_next = '0;
            end else if (ei_cnt_reg != EI_W'(EI_FILT)) begin
               ei_cnt_next = ei_cnt_reg + EI_W'(1);
            end
         end

         always_ff @(posedge PCLK) begin
            if (RESET) begin
               ei_cnt_reg <= '0;
               ei_reg     <= 1'b1;
            end else begin
               ei_cnt_reg <= ei_cnt_next;
               ei_reg     <= (ei_cnt_next != EI_W'(EI_FILT));
            end
         end

         assign RxElecIdle[gi] = ei_reg;
      end
   endgenerate

   assign PhyStatus       = phy_status_reg;
   assign RxStatus        = rx_status_reg;
   assign ffc_pcie_det_en = det_en_reg;
   assign ffc_pcie_ct     = ct_reg;
   assign cur_pd          = cur_pd_reg;

endmodule

// File: tb/tb_pipe_pwr_ctrl_xn.sv
// Directed self-checking bench for pipe_pwr_ctrl_xn with four lanes.
module tb_pipe_pwr_ctrl_xn;

   localparam int NL = 4;

   logic          PCLK;
   logic          RESET;
   logic [1:0]    PowerDown;
   logic          TxDetectRx_Loopback;
   logic [NL-1:0] TxElecIdle;
   logic          ffs_plol;
   logic [NL-1:0] ffs_rlol;
   logic [NL-1:0] rx_ei_raw;
   logic [NL-1:0] ffs_pcie_done;
   logic [NL-1:0] ffs_pcie_con;
   logic          PhyStatus;
   logic [3*NL-1:0] RxStatus;
   logic [NL-1:0] RxElecIdle;
   logic          ffc_pcie_det_en;
   logic          ffc_pcie_ct;
   logic [1:0]    cur_pd;

   int errors = 0;
   int checks = 0;
   int n;

   pipe_pwr_ctrl_xn #(
      .NUM_LANES(NL), .LOCK_WAIT(32), .DET_CT_CYCLES(16), .DET_TIMEOUT(255), .EI_FILT(8)
   ) dut (
      .PCLK(PCLK), .RESET(RESET), .PowerDown(PowerDown),
      .TxDetectRx_Loopback(TxDetectRx_Loopback), .TxElecIdle(TxElecIdle),
      .ffs_plol(ffs_plol), .ffs_rlol(ffs_rlol), .rx_ei_raw(rx_ei_raw),
      .ffs_pcie_done(ffs_pcie_done), .ffs_pcie_con(ffs_pcie_con),
      .PhyStatus(PhyStatus), .RxStatus(RxStatus), .RxElecIdle(RxElecIdle),
      .ffc_pcie_det_en(ffc_pcie_det_en), .ffc_pcie_ct(ffc_pcie_ct), .cur_pd(cur_pd)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      RESET = 1'b1; PowerDown = 2'b10; TxDetectRx_Loopback = 1'b0; TxElecIdle = '1;
      ffs_plol = 1'b0; ffs_rlol = '0; rx_ei_raw = '1; ffs_pcie_done = '0; ffs_pcie_con = '0;
      repeat (3) tick();
      chk("rst_phystatus", 32'(PhyStatus), 32'd1);
      chk("rst_rxstatus", 32'(RxStatus), 32'h0);
      chk("rst_rxelecidle", 32'(RxElecIdle), 32'hF);
      chk("rst_det_en", 32'(ffc_pcie_det_en), 32'd0);
      chk("rst_ct", 32'(ffc_pcie_ct), 32'd0);
      chk("rst_cur_pd", 32'(cur_pd), 32'h2);

      // Lock acquisition: PhyStatus stays high for 32 cycles after reset release
      RESET = 1'b0;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         tick(); n++;
         if (!PhyStatus) break;
      end
      chk("lock_cycles", 32'(n), 32'd32);
      chk("lock_cur_pd", 32'(cur_pd), 32'h2);
      chk("lock_rxelecidle", 32'(RxElecIdle), 32'hF);

      // Back-to-back power changes
      PowerDown = 2'b00; tick();
      chk("pd0_phystatus", 32'(PhyStatus), 32'd1);
      chk("pd0_cur_pd", 32'(cur_pd), 32'h0);
      PowerDown = 2'b01; tick();
      chk("pd0s_phystatus", 32'(PhyStatus), 32'd1);
      chk("pd0s_cur_pd", 32'(cur_pd), 32'h1);
      tick();
      chk("pd0s_pulse_end", 32'(PhyStatus), 32'd0);
      PowerDown = 2'b00; tick(); tick();
      chk("p0_cur_pd", 32'(cur_pd), 32'h0);
      chk("p0_phystatus", 32'(PhyStatus), 32'd0);

      // Electrical-idle filter on lane 2 in P0
      rx_ei_raw[2] = 1'b0;
      repeat (7) tick();
      chk("ei_low7", 32'(RxElecIdle[2]), 32'd1);
      rx_ei_raw[2] = 1'b1; tick();
      chk("ei_glitch", 32'(RxElecIdle[2]), 32'd1);
      rx_ei_raw[2] = 1'b0;
      repeat (7) tick();
      chk("ei_low7_again", 32'(RxElecIdle[2]), 32'd1);
      tick();
      chk("ei_low8", 32'(RxElecIdle), 32'hB);
      ffs_rlol[2] = 1'b1; tick();
      chk("ei_rlol", 32'(RxElecIdle[2]), 32'd1);
      ffs_rlol[2] = 1'b0; rx_ei_raw[2] = 1'b1;

      // Detect request in P0 is loopback and must not start a detect
      TxDetectRx_Loopback = 1'b1; tick(); tick();
      chk("p0_no_detect", 32'(ffc_pcie_det_en), 32'd0);
      TxDetectRx_Loopback = 1'b0;

      // Receiver detect with done arriving 40 cycles after ct ends
      PowerDown = 2'b10; tick(); tick();
      chk("p1_cur_pd", 32'(cur_pd), 32'h2);
      chk("p1_rxelecidle", 32'(RxElecIdle), 32'hF);
      ffs_pcie_con = 4'b0101; TxDetectRx_Loopback = 1'b1;
      tick();
      chk("det_en_1", 32'({ffc_pcie_det_en, ffc_pcie_ct}), 32'h2);
      tick();
      chk("det_en_2", 32'({ffc_pcie_det_en, ffc_pcie_ct}), 32'h2);
      tick();
      chk("ct_start", 32'({ffc_pcie_det_en, ffc_pcie_ct}), 32'h3);
      n = 1;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (!ffc_pcie_ct) break;
         n++;
      end
      chk("ct_width", 32'(n), 32'd16);
      chk("wait_det_en", 32'(ffc_pcie_det_en), 32'd1);
      repeat (39) tick();
      chk("wait_no_status", 32'(PhyStatus), 32'd0);
      ffs_pcie_done = '1; tick();
      chk("res_phystatus", 32'(PhyStatus), 32'd1);
      chk("res_rxstatus", 32'(RxStatus), 32'h0C3);
      chk("res_det_en", 32'(ffc_pcie_det_en), 32'd0);
      ffs_pcie_done = '0; tick();
      chk("hold_phystatus", 32'(PhyStatus), 32'd0);
      chk("hold_rxstatus", 32'(RxStatus), 32'h0);
      repeat (5) tick();
      chk("hold_no_redetect", 32'(ffc_pcie_det_en), 32'd0);

      // Re-arm by dropping the request, then detect with done never asserting
      TxDetectRx_Loopback = 1'b0; tick();
      TxDetectRx_Loopback = 1'b1; tick();
      chk("to_det_en", 32'(ffc_pcie_det_en), 32'd1);
      tick(); tick();
      chk("to_ct_start", 32'(ffc_pcie_ct), 32'd1);
      for (int i = 0; i < 100; i++) begin
         tick();
         if (!ffc_pcie_ct) break;
      end
      n = 0;
      for (int i = 0; i < 400; i++) begin
         tick(); n++;
         if (PhyStatus) break;
      end
      chk("to_cycles", 32'(n), 32'd255);
      chk("to_rxstatus", 32'(RxStatus), 32'h0);
      chk("to_det_en_off", 32'(ffc_pcie_det_en), 32'd0);
      tick();
      TxDetectRx_Loopback = 1'b0; tick();

      // Lock loss during the detect wait, with a P2 request pending
      TxDetectRx_Loopback = 1'b1; tick(); tick(); tick();
      chk("ll_ct_start", 32'(ffc_pcie_ct), 32'd1);
      for (int i = 0; i < 100; i++) begin
         tick();
         if (!ffc_pcie_ct) break;
      end
      repeat (5) tick();
      ffs_plol = 1'b1; PowerDown = 2'b11; tick();
      chk("ll_outputs", 32'({PhyStatus, ffc_pcie_det_en, ffc_pcie_ct}), 32'h4);
      chk("ll_cur_pd", 32'(cur_pd), 32'h2);
      ffs_plol = 1'b0; TxDetectRx_Loopback = 1'b0;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         tick(); n++;
         if (!PhyStatus) break;
      end
      chk("relock_cycles", 32'(n), 32'd32);
      tick();
      chk("relock_pulse", 32'(PhyStatus), 32'd1);
      chk("relock_cur_pd", 32'(cur_pd), 32'h3);
      tick();
      chk("relock_pulse_end", 32'(PhyStatus), 32'd0);

      // Reset asserted together with a power change wins
      PowerDown = 2'b00; RESET = 1'b1; tick();
      chk("rst2_phystatus", 32'(PhyStatus), 32'd1);
      chk("rst2_cur_pd", 32'(cur_pd), 32'h2);
      chk("rst2_rxelecidle", 32'(RxElecIdle), 32'hF);
      RESET = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_pwr_ctrl_xn.md
Name: pipe_pwr_ctrl_xn

Overview:
- Parametrised PIPE power-state and receiver-detect controller for an N-lane ECP3 PCIe PHY wrapper.
- Sits between the link layer's PIPE control signals and the SERDES/PCS quad.
- Generates PhyStatus, per-lane RxStatus detect results, the SERDES detect enable/charge-time strobes, and filtered per-lane RxElecIdle.
- Extends the fixed x1 PHY behaviour to NUM_LANES lanes, with explicit PLL-lock gating, detect timeout and electrical-idle debounce.

Parameters:
- NUM_LANES, 4, number of PIPE lanes (1..8).
- LOCK_WAIT, 32, consecutive PCLK cycles of ffs_plol low required before PhyStatus deasserts after reset or lock loss.
- DET_CT_CYCLES, 16, width of ffc_pcie_ct charge-time pulse.
- DET_TIMEOUT, 255, maximum cycles from ct deassertion to abort detect.
- EI_FILT, 8, consecutive raw-active cycles before RxElecIdle deasserts.

Ports:
- PCLK  in  1  PIPE clock; all logic on rising edge.
- RESET  in  1  synchronous active-high reset.
- PowerDown  in  2  requested power state: 00 P0, 01 P0s, 10 P1, 11 P2.
- TxDetectRx_Loopback  in  1  receiver-detect request (valid in P1 only).
- TxElecIdle  in  NUM_LANES  per-lane transmit electrical idle.
- ffs_plol  in  1  SERDES PLL loss of lock.
- ffs_rlol  in  NUM_LANES  per-lane CDR loss of lock.
- rx_ei_raw  in  NUM_LANES  per-lane raw SERDES loss-of-signal.
- ffs_pcie_done  in  NUM_LANES  per-lane detect complete.
- ffs_pcie_con  in  NUM_LANES  per-lane receiver present.
- PhyStatus  out  1  PIPE PhyStatus.
- RxStatus  out  3*NUM_LANES  per-lane RxStatus; lane i uses bits [3i+2:3i].
- RxElecIdle  out  NUM_LANES  filtered electrical idle.
- ffc_pcie_det_en  out  1  SERDES detect enable.
- ffc_pcie_ct  out  1  SERDES detect charge-time strobe.
- cur_pd  out  2  current acknowledged power state.

Behaviour:
- Reset values (RESET high):
  - state = ST_LOCK, PhyStatus = 1, RxStatus = 0, RxElecIdle = all 1.
  - det_en = 0, ct = 0, cur_pd = 2'b10 (P1), all counters 0.
- ST_LOCK:
  - PhyStatus is held 1. A lock counter increments while ffs_plol = 0 and clears whenever ffs_plol = 1.
  - When the counter reaches LOCK_WAIT-1: next cycle PhyStatus = 0, state -> ST_IDLE, cur_pd = 2'b10.
- Lock loss:
  - ffs_plol = 1 in any state other than ST_LOCK: next cycle state -> ST_LOCK, PhyStatus = 1.
  - Any detect in progress is aborted (det_en = 0, ct = 0, RxStatus = 0). cur_pd is unchanged.
- ST_IDLE power change:
  - If PowerDown != cur_pd is sampled at edge N: cur_pd = PowerDown at N+1, and PhyStatus = 1 for exactly that cycle.
  - A further change in the following cycle produces another independent one-cycle pulse.
  - PowerDown changes in any state other than ST_IDLE are ignored until ST_IDLE is re-entered; they are then serviced as above.
- Detect start: from ST_IDLE, requires cur_pd == P1, TxDetectRx_Loopback = 1, all TxElecIdle = 1 and PowerDown == cur_pd.
  - Power change takes priority when both conditions hold on the same edge.
  - Detect sequence:
    - ST_DET_EN: det_en = 1 for 2 cycles.
    - ST_DET_CT: ct = 1 for DET_CT_CYCLES cycles.
    - ST_DET_WAIT: det_en stays 1; wait until all ffs_pcie_done = 1, or until DET_TIMEOUT cycles elapse.
- ST_DET_RES (1 cycle):
  - det_en = 0 and PhyStatus = 1.
  - Lane i RxStatus = 3'b011 if ffs_pcie_con[i] = 1 and done was reached; otherwise 3'b000.
  - On timeout, all lanes report 3'b000.
- ST_DET_HOLD: RxStatus returns to 0. Wait for TxDetectRx_Loopback = 0, then go to ST_IDLE; no re-detect without a deassertion.
- RxStatus is 000 on all cycles except ST_DET_RES.
- TxDetectRx_Loopback in P0 (loopback) is ignored by this block.
- RxElecIdle, per lane:
  - Forced 1 when cur_pd is P1 or P2, when ffs_rlol[i] = 1, or when state is ST_LOCK.
  - Otherwise it goes to 1 the cycle after rx_ei_raw[i] = 1.
  - It goes to 0 only after rx_ei_raw[i] = 0 for EI_FILT consecutive cycles.
  - A single raw high pulse restarts the filter count.
- Counters saturate and never wrap. The lock counter is sized for LOCK_WAIT and the timeout counter for DET_TIMEOUT.
- RESET asserted mid-detect or mid-pulse: all outputs return to their reset values on the next edge.

Test Plan:
- Release reset with ffs_plol = 0 -> PhyStatus stays 1 for exactly 32 cycles, then 0; cur_pd = 10; RxElecIdle = 1111.
- After lock, drive PowerDown 10 -> 00 -> one-cycle PhyStatus one cycle after the change, cur_pd = 00. Then PowerDown 00 -> 01 on the very next cycle -> a second one-cycle pulse, cur_pd = 01.
- In P1, TxElecIdle = 1111, TxDetectRx_Loopback = 1, ffs_pcie_con = 0101, all ffs_pcie_done rising 40 cycles after ct ends:
  - det_en high 2 cycles before ct; ct high for 16 cycles.
  - Result cycle: PhyStatus = 1, RxStatus = {000, 011, 000, 011} for lanes 3..0.
  - No re-detect until TxDetectRx_Loopback drops.
- Same detect with ffs_pcie_done never asserting -> PhyStatus pulse 255 cycles after ct ends, RxStatus all 000.
- In P0, lane 2 rx_ei_raw goes low for 7 cycles, high 1 cycle, then low 8 cycles -> RxElecIdle[2] deasserts only after the second run of 8 cycles. ffs_rlol[2] = 1 -> RxElecIdle[2] = 1 the next cycle.
- ffs_plol pulses high during ST_DET_WAIT -> det_en and ct drop and PhyStatus = 1 the next cycle. PowerDown = 11 is applied meanwhile; after relock (32 cycles) one PhyStatus pulse follows and cur_pd = 11.
